rotor_bank: RTL and testbench

ROTOR_BANK -- requirements
Module: rotor_bank

---
 rtl/rotor_bank.sv | 219 +++++++++++++++++++++
 tb/tb_rotor_bank.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotor_bank.sv
// Rotor bank cipher: stepping rotor chain with per-rotor wiring tables and a valid/ready handshake.
// Optional reflector stage enabled by defining ROTOR_BANK_REFLECTOR_EN.
`timescale 1ns/1ps
module rotor_bank #(
  parameter int NUM_ROTORS = 3,
  parameter int ALPHA      = 26,
  parameter int BASE       = 65,
  parameter int SYM_W      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_sel,
  input  logic [4:0]             cfg_offset,
  input  logic [4:0]             cfg_step,
  input  logic [4:0]             cfg_notch,
  input  logic [ALPHA*SYM_W-1:0] cfg_map,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SYM_W-1:0]       in_char,
  input  logic                   in_dec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SYM_W-1:0]       out_char,
  output logic                   err
);

  typedef enum logic [1:0] {IDLE, STEP, XLAT, OUT} state_t;
  typedef logic [SYM_W:0] wide_t;

  localparam wide_t ALPHA_W = wide_t'(ALPHA);
  localparam wide_t BASE_W  = wide_t'(BASE);
`ifdef ROTOR_BANK_REFLECTOR_EN
  localparam int XLAT_CYC = 2*NUM_ROTORS+1;
`else
  localparam int XLAT_CYC = NUM_ROTORS;
`endif
  localparam logic [3:0] LAST_CNT = 4'(XLAT_CYC-1);
  localparam logic [3:0] N_CNT    = 4'(NUM_ROTORS);

  state_t           state_q;
  logic [4:0]       pos_q   [NUM_ROTORS];
  logic [4:0]       notch_q [NUM_ROTORS];
  logic [4:0]       step_q;
  logic [SYM_W-1:0] map_q   [NUM_ROTORS][ALPHA];
  logic [SYM_W-1:0] char_q;
  logic             dec_q;
  logic [3:0]       cnt_q;
  logic             outValid_q;
  logic [SYM_W-1:0] outChar_q;
  logic             err_q;

  logic [4:0]       pos_d [NUM_ROTORS];
  logic [SYM_W-1:0] char_d;
  logic             xlatErr_d;

  logic [1:0]       rotSel;
  logic             inverse;
  logic             reflect;
  logic [SYM_W-1:0] selMap [ALPHA];
  wide_t            selPos;
  wide_t            symIdx;
  wide_t            mapIdx;
  wide_t            hitIdx;
  logic             hit;

  // Operands are always below ALPHA, so a single conditional subtraction suffices.
  function automatic wide_t modAlpha(input wide_t a, input wide_t b);
    wide_t s;
    s = a + b;
    return (s >= ALPHA_W) ? s - ALPHA_W : s;
  endfunction

  function automatic logic [4:0] cfgReduce(input logic [4:0] v);
    return (wide_t'(v) >= ALPHA_W) ? 5'(wide_t'(v) - ALPHA_W) : v;
  endfunction

  function automatic logic inAlpha(input logic [SYM_W-1:0] c);
    return (wide_t'(c) >= BASE_W) && (wide_t'(c) < BASE_W + ALPHA_W);
  endfunction

  // Carries look at pre-step positions, so every rotor updates in the same cycle.
  always_comb begin
    pos_d[0] = 5'(modAlpha(wide_t'(pos_q[0]), wide_t'(step_q)));
    for (int r = 1; r < NUM_ROTORS; r++) begin
      pos_d[r] = 5'(modAlpha(wide_t'(pos_q[r]),
                             (pos_q[r-1] == notch_q[r-1]) ? wide_t'(1) : wide_t'(0)));
    end
  end

  always_comb begin
    rotSel  = '0;
    inverse = 1'b0;
    reflect = 1'b0;
`ifdef ROTOR_BANK_REFLECTOR_EN
    if (cnt_q < N_CNT) begin
      rotSel = 2'(cnt_q);
    end else if (cnt_q == N_CNT) begin
      reflect = 1'b1;
    end else begin
      rotSel  = 2'(4'(2*NUM_ROTORS) - cnt_q);
      inverse = 1'b1;
    end
`else
    inverse = dec_q;
    rotSel  = dec_q ? 2'(N_CNT - 4'd1 - cnt_q) : 2'(cnt_q);
`endif
  end

  always_comb begin
    selPos = '0;
    for (int i = 0; i < ALPHA; i++) selMap[i] = '0;
    for (int r = 0; r < NUM_ROTORS; r++) begin
      if (rotSel == 2'(r)) begin
        selPos = wide_t'(pos_q[r]);
        for (int i = 0; i < ALPHA; i++) selMap[i] = map_q[r][i];
      end
    end
  end

  // Descending scan leaves the lowest matching index in hitIdx.
  always_comb begin
    symIdx    = wide_t'(char_q) - BASE_W;
    mapIdx    = modAlpha(symIdx, selPos);
    hit       = 1'b0;
    hitIdx    = '0;
    char_d    = char_q;
    xlatErr_d = 1'b0;
    for (int i = ALPHA-1; i >= 0; i--) begin
      if (selMap[i] == char_q) begin
        hit    = 1'b1;
        hitIdx = wide_t'(i);
      end
    end
    if (reflect) begin
      if (inAlpha(char_q)) char_d = SYM_W'(BASE_W + ALPHA_W - wide_t'(1) - symIdx);
    end else if (inverse) begin
      if (hit) begin
        char_d = SYM_W'(BASE_W + modAlpha(hitIdx, ALPHA_W - selPos));
      end else begin
        char_d    = SYM_W'(63);
        xlatErr_d = 1'b1;
      end
    end else if (inAlpha(char_q)) begin
      for (int i = 0; i < ALPHA; i++) begin
        if (mapIdx == wide_t'(i)) char_d = selMap[i];
      end
    end
  end

  // OUT spends one cycle loading the result register before raising out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      step_q     <= '0;
      char_q     <= '0;
      dec_q      <= 1'b0;
      cnt_q      <= '0;
      outValid_q <= 1'b0;
      outChar_q  <= '0;
      err_q      <= 1'b0;
      for (int r = 0; r < NUM_ROTORS; r++) begin
        pos_q[r]   <= '0;
        notch_q[r] <= '0;
        for (int i = 0; i < ALPHA; i++) map_q[r][i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_we) begin
            for (int r = 0; r < NUM_ROTORS; r++) begin
              if (cfg_sel == 2'(r)) begin
                pos_q[r]   <= cfgReduce(cfg_offset);
                notch_q[r] <= cfgReduce(cfg_notch);
                for (int i = 0; i < ALPHA; i++) begin
                  map_q[r][i] <= cfg_map[(ALPHA-1-i)*SYM_W +: SYM_W];
                end
                if (r == 0) step_q <= cfgReduce(cfg_step);
              end
            end
          end
          if (in_valid) begin
            char_q  <= in_char;
            dec_q   <= in_dec;
            state_q <= inAlpha(in_char) ? STEP : OUT;
          end
        end
        STEP: begin
          for (int r = 0; r < NUM_ROTORS; r++) pos_q[r] <= pos_d[r];
          cnt_q   <= '0;
          state_q <= XLAT;
        end
        XLAT: begin
          char_q <= char_d;
          if (xlatErr_d) err_q <= 1'b1;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) state_q <= OUT;
        end
        OUT: begin
          if (!outValid_q) begin
            outValid_q <= 1'b1;
            outChar_q  <= char_q;
          end else if (out_ready) begin
            outValid_q <= 1'b0;
            outChar_q  <= '0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = outValid_q;
  assign out_char  = outChar_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rotor_bank.sv
// Self-checking bench for rotor_bank: a behavioural cipher model plus hand-computed literal vectors.
`timescale 1ns/1ps
module tb_rotor_bank;

  localparam int N     = 3;
  localparam int ALPHA = 26;
  localparam int BASE  = 65;
  localparam int SYM_W = 8;
`ifdef ROTOR_BANK_REFLECTOR_EN
  localparam int XLAT_CYC = 2*N+1;
`else
  localparam int XLAT_CYC = N;
`endif
  localparam int EXP_LAT = XLAT_CYC + 2;

  logic                   clk;
  logic                   reset;
  logic                   cfg_we;
  logic [1:0]             cfg_sel;
  logic [4:0]             cfg_offset;
  logic [4:0]             cfg_step;
  logic [4:0]             cfg_notch;
  logic [ALPHA*SYM_W-1:0] cfg_map;
  logic                   in_valid;
  logic                   in_ready;
  logic [SYM_W-1:0]       in_char;
  logic                   in_dec;
  logic                   out_valid;
  logic                   out_ready;
  logic [SYM_W-1:0]       out_char;
  logic                   err;

  rotor_bank #(.NUM_ROTORS(N), .ALPHA(ALPHA), .BASE(BASE), .SYM_W(SYM_W)) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_offset(cfg_offset), .cfg_step(cfg_step),
    .cfg_notch(cfg_notch), .cfg_map(cfg_map),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_dec(in_dec),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  int  mPos   [N];
  int  mNotch [N];
  int  mMap   [N][ALPHA];
  int  mStep;
  bit  mErr;
  int  expChar[$];
  bit  expErr[$];

  logic [7:0] lastOut;
  logic [7:0] outBuf    [16];
  logic [7:0] cipherBuf [16];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit isAlpha(int c);
    return (c >= BASE) && (c < BASE + ALPHA);
  endfunction

  function automatic int mapEntry(int mode, int i);
    case (mode)
      0:       return BASE + i;
      1:       return BASE + (7*i + 3) % ALPHA;
      2:       return BASE + (5*i + 11) % ALPHA;
      default: return BASE;
    endcase
  endfunction

  function automatic int fwdRotor(int r, int c);
    if (!isAlpha(c)) return c;
    return mMap[r][(c - BASE + mPos[r]) % ALPHA];
  endfunction

  function automatic int invRotor(int r, int c);
    for (int i = 0; i < ALPHA; i++) begin
      if (mMap[r][i] == c) return BASE + (i - mPos[r] + ALPHA) % ALPHA;
    end
    mErr = 1'b1;
    return 'h3F;
  endfunction

  function automatic int modelChar(int ch, bit dec);
    int old [N];
    int c;
    if (!isAlpha(ch)) return ch;
    old = mPos;
    mPos[0] = (old[0] + mStep) % ALPHA;
    for (int r = 1; r < N; r++) begin
      if (old[r-1] == mNotch[r-1]) mPos[r] = (old[r] + 1) % ALPHA;
    end
    c = ch;
`ifdef ROTOR_BANK_REFLECTOR_EN
    for (int r = 0; r < N; r++) c = fwdRotor(r, c);
    if (isAlpha(c)) c = BASE + (ALPHA - 1 - (c - BASE));
    for (int r = N-1; r >= 0; r--) c = invRotor(r, c);
`else
    if (dec) begin
      for (int r = N-1; r >= 0; r--) c = invRotor(r, c);
    end else begin
      for (int r = 0; r < N; r++) c = fwdRotor(r, c);
    end
`endif
    return c;
  endfunction

  task automatic modelReset();
    for (int r = 0; r < N; r++) begin
      mPos[r]   = 0;
      mNotch[r] = 0;
      for (int i = 0; i < ALPHA; i++) mMap[r][i] = 0;
    end
    mStep = 0;
    mErr  = 1'b0;
    expChar.delete();
    expErr.delete();
  endtask

  // Compare process: every cycle out_valid is high the output must match the model.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1) begin
      if (expChar.size() == 0) begin
        checkOutput("unexpected out_valid", out_valid, 0);
      end else begin
        checkOutput("model out_char", out_char, expChar[0]);
        checkOutput("model err", err, expErr[0]);
        if (out_ready === 1'b1) begin
          void'(expChar.pop_front());
          void'(expErr.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic configRotor(input int sel, input int off, input int stp, input int notch, input int mode);
    cfg_sel    = 2'(sel);
    cfg_offset = 5'(off);
    cfg_step   = 5'(stp);
    cfg_notch  = 5'(notch);
    for (int i = 0; i < ALPHA; i++) cfg_map[(ALPHA-1-i)*SYM_W +: SYM_W] = 8'(mapEntry(mode, i));
    cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (sel < N) begin
      mPos[sel]   = off % ALPHA;
      mNotch[sel] = notch % ALPHA;
      if (sel == 0) mStep = stp % ALPHA;
      for (int i = 0; i < ALPHA; i++) mMap[sel][i] = mapEntry(mode, i);
    end
  endtask

  task automatic configN1();
    configRotor(0, 0, 1, 25, 0);
    configRotor(1, 0, 0, 5, 0);
    configRotor(2, 0, 0, 5, 0);
  endtask

  task automatic configMixed();
    configRotor(0, 3, 3, 8, 1);
    configRotor(1, 10, 0, 14, 2);
    configRotor(2, 25, 0, 0, 1);
    configRotor(3, 7, 7, 7, 3);
  endtask

  task automatic applyStimulus(input int ch, input bit dec, input int holdCycles);
    int n;
    int lat;
    in_char  = 8'(ch);
    in_dec   = dec;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      checkOutput("in_ready timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    expChar.push_back(modelChar(ch, dec));
    expErr.push_back(mErr);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", lat, isAlpha(ch) ? EXP_LAT : 1);
    if (out_valid !== 1'b1) begin
      expChar.delete();
      expErr.delete();
      return;
    end
    if (holdCycles > 0) begin
      in_char  = "Q";
      in_valid = 1'b1;
    end
    for (int h = 0; h < holdCycles; h++) begin
      @(posedge clk); #1;
      checkOutput("hold in_ready", in_ready, 0);
      checkOutput("hold out_valid", out_valid, 1);
      if (expChar.size() > 0) checkOutput("hold out_char", out_char, expChar[0]);
    end
    in_valid  = 1'b0;
    lastOut   = out_char;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("out_valid after transfer", out_valid, 0);
  endtask

  task automatic sendString(input string s, input bit dec);
    for (int i = 0; i < s.len(); i++) begin
      applyStimulus(int'(s[i]), dec, 0);
      outBuf[i] = lastOut;
    end
  endtask

  task automatic checkString(input string name, input string expected);
    for (int i = 0; i < expected.len(); i++) checkOutput(name, outBuf[i], expected[i]);
  endtask

  // Encrypting then decrypting (or re-encrypting with the reflector) must restore the plaintext.
  task automatic roundTrip(input string plain);
    configMixed();
    sendString(plain, 1'b0);
    for (int i = 0; i < plain.len(); i++) cipherBuf[i] = outBuf[i];
    configMixed();
    for (int i = 0; i < plain.len(); i++) begin
      applyStimulus(int'(cipherBuf[i]), 1'b1, 0);
      outBuf[i] = lastOut;
    end
    checkString("roundtrip", plain);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_offset = '0; cfg_step = '0; cfg_notch = '0;
    cfg_map = '0; in_valid = 1'b0; in_char = '0; in_dec = 1'b0; out_ready = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_char", out_char, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset in_ready", in_ready, 1);

    configN1();
    sendString("AAA", 1'b0);
`ifndef ROTOR_BANK_REFLECTOR_EN
    checkString("encrypt AAA", "BCD");
`endif

    configN1();
    sendString("BCD", 1'b1);
`ifndef ROTOR_BANK_REFLECTOR_EN
    checkString("decrypt BCD", "AAA");
`endif
    checkOutput("err after clean decrypt", err, 0);

    configRotor(0, 24, 1, 25, 0);
    configRotor(1, 0, 0, 5, 0);
    configRotor(2, 0, 0, 5, 0);
    sendString("AA", 1'b0);
`ifndef ROTOR_BANK_REFLECTOR_EN
    checkString("notch carry", "ZB");
`endif

    applyStimulus('h35, 1'b0, 0);
    checkOutput("passthrough", lastOut, 'h35);
    applyStimulus("A", 1'b0, 0);
`ifndef ROTOR_BANK_REFLECTOR_EN
    checkOutput("no step on passthrough", lastOut, "C");
`endif

    roundTrip("HELLOWORLD");

    applyStimulus("K", 1'b0, 5);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("single transfer after hold", out_valid, 0);

    configRotor(0, 0, 1, 25, 3);
    configRotor(1, 0, 0, 5, 0);
    configRotor(2, 0, 0, 5, 0);
    applyStimulus("B", 1'b1, 0);
`ifndef ROTOR_BANK_REFLECTOR_EN
    checkOutput("no inverse match", lastOut, 'h3F);
    checkOutput("err set", err, 1);
    applyStimulus("A", 1'b1, 0);
    checkOutput("decrypt after err", lastOut, "Y");
    checkOutput("err sticky", err, 1);
`endif

    in_char = "M"; in_dec = 1'b0; in_valid = 1'b1;
    checkOutput("pre-reset in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    checkOutput("reset mid-xlat out_valid", out_valid, 0);
    checkOutput("reset mid-xlat out_char", out_char, 0);
    checkOutput("reset mid-xlat err", err, 0);
    modelReset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    configN1();
    in_char = "A"; in_dec = 1'b0; in_valid = 1'b1;
    checkOutput("pre-out in_ready", in_ready, 1);
    expChar.push_back(modelChar("A", 1'b0));
    expErr.push_back(mErr);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (EXP_LAT) begin @(posedge clk); #1; end
    checkOutput("valid before reset", out_valid, 1);
    reset = 1'b1;
    #1;
    checkOutput("out_valid drops on reset", out_valid, 0);
    checkOutput("out_char clears on reset", out_char, 0);
    modelReset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("err after reset", err, 0);

    configN1();
    applyStimulus("A", 1'b0, 0);
`ifndef ROTOR_BANK_REFLECTOR_EN
    checkOutput("encrypt after reset", lastOut, "B");
`endif
    roundTrip("HELLO");
    checkString("hello restored", "HELLO");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
